// File: rtl/menor_pkg.sv
// Shared definitions for the less-than comparator arbiter:
// buffer state encoding, requester-id width/count and requester ids.
package menor_pkg;

    typedef enum logic {
        VACIO = 1'b0,
        LLENO = 1'b1
    } estado_t;

    localparam int ID_W    = 1;
    localparam int N_SOLIC = 2;

    localparam logic [ID_W-1:0] SOLIC_ALU   = 1'b0;
    localparam logic [ID_W-1:0] SOLIC_SALTO = 1'b1;

endpackage

// File: rtl/fn_menor.sv
// fn_menor: combinational A < B comparator, signed or unsigned.
// Ports: a, b (ANCHO bits), sin_signo (1 = unsigned), y (1 if a < b).
module fn_menor #(
    parameter int ANCHO = 32
) (
    input  logic [ANCHO-1:0] a,
    input  logic [ANCHO-1:0] b,
    input  logic             sin_signo,
    output logic             y
);

    always_comb begin
        if (sin_signo) y = (a < b);
        else           y = ($signed(a) < $signed(b));
    end

endmodule

// File: rtl/arbitro_menor.sv
// arbitro_menor: shares one fn_menor between the ALU (id 0) and the
// branch unit (id 1) with valid/ready handshakes and a 1-entry result
// buffer. Ports: clk, nreset (async, active-low); per requester i:
// req_valid_i/req_ready_i, a_i, b_i, sin_signo_i, resp_valid_i,
// resp_ready_i; shared resp_y. Optional macro ARBITRO_MENOR_RR_EN
// selects round-robin on ties; otherwise requester 0 always wins.
module arbitro_menor
    import menor_pkg::*;
#(
    parameter int ANCHO = 32
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             req_valid_0,
    input  logic             req_valid_1,
    output logic             req_ready_0,
    output logic             req_ready_1,
    input  logic [ANCHO-1:0] a_0,
    input  logic [ANCHO-1:0] a_1,
    input  logic [ANCHO-1:0] b_0,
    input  logic [ANCHO-1:0] b_1,
    input  logic             sin_signo_0,
    input  logic             sin_signo_1,
    output logic             resp_valid_0,
    output logic             resp_valid_1,
    input  logic             resp_ready_0,
    input  logic             resp_ready_1,
    output logic             resp_y
);

    estado_t         estado_q;
    logic [ID_W-1:0] dueno_q;
    logic            y_q;

    logic [ID_W-1:0] dueno_d;
    logic            y_d;
    logic [ID_W-1:0] empate;
    logic            drena;
    logic            libre;
    logic            acepta;
    logic [ANCHO-1:0] a_g;
    logic [ANCHO-1:0] b_g;
    logic             s_g;

`ifdef ARBITRO_MENOR_RR_EN
    logic [ID_W-1:0] ultimo_q;
    // On a tie, favour whoever was not granted last.
    assign empate = ~ultimo_q;
`else
    assign empate = SOLIC_ALU;
`endif

    // Granted id: the sole requester, or the tie winner.
    always_comb begin
        dueno_d = SOLIC_ALU;
        if (req_valid_0 && req_valid_1) dueno_d = empate;
        else if (req_valid_1)           dueno_d = SOLIC_SALTO;
    end

    assign drena  = (estado_q == LLENO) &&
                    ((dueno_q == SOLIC_SALTO) ? resp_ready_1
                                              : resp_ready_0);
    assign libre  = (estado_q == VACIO) || drena;
    assign acepta = libre && (req_valid_0 || req_valid_1);

    // Reset also forces ready low while the buffer is held empty.
    assign req_ready_0 = nreset && libre && req_valid_0 &&
                         (dueno_d == SOLIC_ALU);
    assign req_ready_1 = nreset && libre && req_valid_1 &&
                         (dueno_d == SOLIC_SALTO);

    assign a_g = (dueno_d == SOLIC_SALTO) ? a_1 : a_0;
    assign b_g = (dueno_d == SOLIC_SALTO) ? b_1 : b_0;
    assign s_g = (dueno_d == SOLIC_SALTO) ? sin_signo_1 : sin_signo_0;

    fn_menor #(
        .ANCHO (ANCHO)
    ) u_fn_menor (
        .a         (a_g),
        .b         (b_g),
        .sin_signo (s_g),
        .y         (y_d)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            estado_q <= VACIO;
            dueno_q  <= SOLIC_ALU;
            y_q      <= 1'b0;
`ifdef ARBITRO_MENOR_RR_EN
            ultimo_q <= SOLIC_SALTO;
`endif
        end else if (acepta) begin
            estado_q <= LLENO;
            dueno_q  <= dueno_d;
            y_q      <= y_d;
`ifdef ARBITRO_MENOR_RR_EN
            ultimo_q <= dueno_d;
`endif
        end else if (drena) begin
            estado_q <= VACIO;
        end
    end

    assign resp_valid_0 = (estado_q == LLENO) && (dueno_q == SOLIC_ALU);
    assign resp_valid_1 = (estado_q == LLENO) && (dueno_q == SOLIC_SALTO);
    assign resp_y       = y_q;

endmodule

// File: tb/tb_arbitro_menor.sv
// Directed bench for arbitro_menor: reset, signed/unsigned compares,
// contention, backpressure, back-to-back throughput, mid-op reset.
module tb_arbitro_menor;

    logic        clk;
    logic        nreset;
    logic        req_valid_0, req_valid_1;
    logic        req_ready_0, req_ready_1;
    logic [31:0] a_0, a_1, b_0, b_1;
    logic        sin_signo_0, sin_signo_1;
    logic        resp_valid_0, resp_valid_1;
    logic        resp_ready_0, resp_ready_1;
    logic        resp_y;

    int total = 0;
    int bad   = 0;

    arbitro_menor #(.ANCHO(32)) dut (
        .clk          (clk),
        .nreset       (nreset),
        .req_valid_0  (req_valid_0),
        .req_valid_1  (req_valid_1),
        .req_ready_0  (req_ready_0),
        .req_ready_1  (req_ready_1),
        .a_0          (a_0),
        .a_1          (a_1),
        .b_0          (b_0),
        .b_1          (b_1),
        .sin_signo_0  (sin_signo_0),
        .sin_signo_1  (sin_signo_1),
        .resp_valid_0 (resp_valid_0),
        .resp_valid_1 (resp_valid_1),
        .resp_ready_0 (resp_ready_0),
        .resp_ready_1 (resp_ready_1),
        .resp_y       (resp_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and report handshake and result observations.
    task automatic do_cmp(input logic id, input logic [31:0] a,
                          input logic [31:0] b, input logic s,
                          output logic rdy, output logic v,
                          output logic y);
        if (id) begin
            a_1 = a; b_1 = b; sin_signo_1 = s; req_valid_1 = 1'b1;
        end else begin
            a_0 = a; b_0 = b; sin_signo_0 = s; req_valid_0 = 1'b1;
        end
        #1;
        rdy = id ? req_ready_1 : req_ready_0;
        @(posedge clk);
        #1;
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        v = id ? resp_valid_1 : resp_valid_0;
        y = resp_y;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
        a_0 = '0; a_1 = '0; b_0 = 32'd1; b_1 = 32'd1;
        sin_signo_0 = 1'b0; sin_signo_1 = 1'b0;
        step();
        total++;
        if ({resp_valid_0, resp_valid_1, resp_y} !== 3'b000) begin
            bad++;
            $display("FAIL reset_resp got=%b want=000",
                     {resp_valid_0, resp_valid_1, resp_y});
        end
        total++;
        if ({req_ready_0, req_ready_1} !== 2'b00) begin
            bad++;
            $display("FAIL reset_ready got=%b want=00",
                     {req_ready_0, req_ready_1});
        end
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        #1;
        nreset = 1'b1;
        step();
    endtask

    task automatic test_signed();
        logic rdy, v, y;
        do_cmp(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, rdy, v, y);
        total++;
        if ({rdy, v, y} !== 3'b111) begin
            bad++;
            $display("FAIL signed_m1_lt_1 got=%b want=111", {rdy, v, y});
        end
        do_cmp(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, rdy, v, y);
        total++;
        if ({rdy, v, y} !== 3'b110) begin
            bad++;
            $display("FAIL unsigned_max_lt_1 got=%b want=110", {rdy, v, y});
        end
        step();
    endtask

    task automatic test_equal();
        logic rdy, v, y;
        logic [31:0] av [4] = '{32'h8000_0000, 32'h8000_0000,
                                32'h8000_0000, 32'h8000_0000};
        logic [31:0] bv [4] = '{32'h8000_0000, 32'h8000_0000,
                                32'h7FFF_FFFF, 32'h7FFF_FFFF};
        logic        sv [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic        ev [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            do_cmp(1'b0, av[i], bv[i], sv[i], rdy, v, y);
            total++;
            if ({rdy, v, y} !== {2'b11, ev[i]}) begin
                bad++;
                $display("FAIL edge_case%0d got=%b want=%b", i,
                         {rdy, v, y}, {2'b11, ev[i]});
            end
        end
        step();
    endtask

    task automatic test_contention();
        logic w;
        logic exp_r0, exp_r1, exp_y;
        // Fresh reset so the round-robin pointer starts at its reset value.
        #2;
        nreset = 1'b0;
        #1;
        nreset = 1'b1;
        a_0 = 32'd1; b_0 = 32'd2; sin_signo_0 = 1'b1;
        a_1 = 32'd2; b_1 = 32'd1; sin_signo_1 = 1'b1;
        resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
        step();
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
`ifdef ARBITRO_MENOR_RR_EN
            w = i[0];
`else
            w = 1'b0;
`endif
            exp_r0 = ~w;
            exp_r1 = w;
            exp_y  = ~w;
            #1;
            total++;
            if ({req_ready_0, req_ready_1} !== {exp_r0, exp_r1}) begin
                bad++;
                $display("FAIL contention_ready%0d got=%b want=%b", i,
                         {req_ready_0, req_ready_1}, {exp_r0, exp_r1});
            end
            step();
            total++;
            if ({resp_valid_0, resp_valid_1, resp_y} !==
                {exp_r0, exp_r1, exp_y}) begin
                bad++;
                $display("FAIL contention_resp%0d got=%b want=%b", i,
                         {resp_valid_0, resp_valid_1, resp_y},
                         {exp_r0, exp_r1, exp_y});
            end
        end
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        logic rdy, v, y;
        resp_ready_1 = 1'b0;
        do_cmp(1'b1, 32'd5, 32'd9, 1'b1, rdy, v, y);
        total++;
        if ({rdy, v, y} !== 3'b111) begin
            bad++;
            $display("FAIL bp_accept got=%b want=111", {rdy, v, y});
        end
        a_0 = 32'd9; b_0 = 32'd5; sin_signo_0 = 1'b1;
        req_valid_0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({resp_valid_1, resp_y, req_ready_0, req_ready_1} !==
                4'b1100) begin
                bad++;
                $display("FAIL bp_hold%0d got=%b want=1100", i,
                         {resp_valid_1, resp_y, req_ready_0, req_ready_1});
            end
            step();
        end
        resp_ready_1 = 1'b1;
        #1;
        total++;
        if (req_ready_0 !== 1'b1) begin
            bad++;
            $display("FAIL bp_drain_ready got=%b want=1", req_ready_0);
        end
        step();
        req_valid_0 = 1'b0;
        total++;
        if ({resp_valid_0, resp_valid_1, resp_y} !== 3'b100) begin
            bad++;
            $display("FAIL bp_after got=%b want=100",
                     {resp_valid_0, resp_valid_1, resp_y});
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic exp_bb [8] = '{1'b1, 1'b0, 1'b1, 1'b0,
                             1'b1, 1'b1, 1'b0, 1'b0};
        resp_ready_1 = 1'b1;
        req_valid_1  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_1 = 32'(i) - 32'd4;
            b_1 = 32'd2;
            sin_signo_1 = i[0];
            #1;
            total++;
            if (req_ready_1 !== 1'b1) begin
                bad++;
                $display("FAIL b2b_ready%0d got=%b want=1", i, req_ready_1);
            end
            step();
            total++;
            if ({resp_valid_1, resp_y} !== {1'b1, exp_bb[i]}) begin
                bad++;
                $display("FAIL b2b_resp%0d got=%b want=%b", i,
                         {resp_valid_1, resp_y}, {1'b1, exp_bb[i]});
            end
        end
        req_valid_1 = 1'b0;
        step();
        total++;
        if (resp_valid_1 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_empty got=%b want=0", resp_valid_1);
        end
    endtask

    task automatic test_reset_mid();
        logic rdy, v, y;
        resp_ready_1 = 1'b0;
        do_cmp(1'b1, 32'd1, 32'd3, 1'b0, rdy, v, y);
        total++;
        if ({rdy, v, y} !== 3'b111) begin
            bad++;
            $display("FAIL rstmid_pending got=%b want=111", {rdy, v, y});
        end
        #2;
        nreset = 1'b0;
        #1;
        total++;
        if ({resp_valid_0, resp_valid_1, resp_y} !== 3'b000) begin
            bad++;
            $display("FAIL rstmid_clear got=%b want=000",
                     {resp_valid_0, resp_valid_1, resp_y});
        end
        #1;
        nreset = 1'b1;
        resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
        a_0 = 32'd7; b_0 = 32'd7; sin_signo_0 = 1'b0;
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        #1;
        total++;
        if ({req_ready_0, req_ready_1} !== 2'b10) begin
            bad++;
            $display("FAIL rstmid_tie got=%b want=10",
                     {req_ready_0, req_ready_1});
        end
        step();
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        total++;
        if ({resp_valid_0, resp_valid_1, resp_y} !== 3'b100) begin
            bad++;
            $display("FAIL rstmid_after got=%b want=100",
                     {resp_valid_0, resp_valid_1, resp_y});
        end
        step();
    endtask

    initial begin
        test_reset();
        test_signed();
        test_equal();
        test_contention();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arbitro_menor.md
# arbitro_menor

Shares one 32-bit less-than comparator (`fn_menor`) between two requesters in the RV32I core: requester 0 is the ALU (SLT/SLTI/SLTU/SLTIU) and requester 1 is the branch unit (BLT/BGE/BLTU/BGEU). The block arbitrates the requests with valid/ready handshakes and computes the comparison. It holds the 1-bit result in a single-entry output buffer until the owning requester accepts it.

## Interface
Parameters:
- `ANCHO`, 32: operand width in bits.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `nreset`  in  1  reset, asynchronous and active-low.
- `req_valid_0`, `req_valid_1`  in  1  request present on requester i.
- `req_ready_0`, `req_ready_1`  out  1  request accepted this cycle.
- `a_0`, `a_1`  in  ANCHO  operand A of requester i.
- `b_0`, `b_1`  in  ANCHO  operand B of requester i.
- `sin_signo_0`, `sin_signo_1`  in  1  operand format: 1 = unsigned, 0 = two's complement.
- `resp_valid_0`, `resp_valid_1`  out  1  result for requester i is available.
- `resp_ready_0`, `resp_ready_1`  in  1  requester i accepts the result.
- `resp_y`  out  1  shared result: 1 if A < B, else 0. Meaning valid only while either `resp_valid_i` is 1.

## Operation
- Output buffer state machine, 2 states:
  - `VACIO`: buffer empty.
  - `LLENO`: buffer holds `y` and `dueno` (owner id).
- Drain: `drena = LLENO & resp_ready_dueno`.
- Accept condition: `libre = VACIO | drena`.
- Grant: at most one requester per cycle.
  - Only one `req_valid_i` high: that requester is granted.
  - Both high: granted per arbitration policy (see Configuration).
- `req_ready_i = libre & grant_i`. Combinational from valids, state and `resp_ready`. A requester is never readied when its `req_valid_i` is low.
- On accept, at the clock edge:
  - `y` ← `fn_menor(a_g, b_g, sin_signo_g)`;
  - `dueno` ← g;
  - state → `LLENO`.
- Drain without accept: state → `VACIO`.
- Drain and accept in the same cycle: state stays `LLENO`, and `y`/`dueno` are overwritten.
- `resp_valid_i = LLENO & (dueno == i)`. `resp_y` is driven from the buffer `y`.
- Held `resp_y` stays stable while `resp_valid_i` is high and `resp_ready_i` is low.
- Requesters must hold `a`, `b` and `sin_signo` stable while `req_valid_i` is high and `req_ready_i` is low. Operands are sampled only at accept.
- Arithmetic:
  - Signed compare uses two's complement over full ANCHO bits.
  - Unsigned compare uses natural binary.
  - Equal operands give 0 in both modes.

## Timing
- Latency: request accepted at edge N → `resp_valid_i` high after edge N, i.e. from cycle N+1.
- Throughput: one comparison per cycle when the owner keeps `resp_ready` high.
- Reset (`nreset` low, asynchronous):
  - state = `VACIO`, `dueno` = 0, `y` = 0, `ultimo` = 1.
  - All `resp_valid_i` = 0, `resp_y` = 0, all `req_ready_i` = 0.
- Reset mid-operation: a pending result is discarded and is never delivered after reset.
- First cycle after reset release: requests are accepted normally; requester 0 wins a tie.
- A requester whose response is pending may request again. Its next request is accepted only in the cycle its response drains, or later.

## Configuration
- Macro `ARBITRO_MENOR_RR_EN`.
- Defined: round-robin arbitration.
  - Pointer `ultimo` records the last granted id and updates only on accept.
  - On a tie, the grant goes to the id ≠ `ultimo`.
- Undefined: fixed priority, requester 0 always wins a tie. `ultimo` is not implemented.

## Structure
- Shared package `menor_pkg` holds:
  - state encoding `VACIO`/`LLENO`;
  - requester-id width constant (1) and `N_SOLIC` = 2;
  - requester-id constants `SOLIC_ALU` = 0 and `SOLIC_SALTO` = 1.
- One sub-module: the existing `fn_menor` comparator, instantiated once and fed by a 2:1 operand mux driven by the grant.
- No other hierarchy.

## Test plan
- Signed vs unsigned:
  - Requester 0: a=0xFFFFFFFF, b=0x00000001, sin_signo=0 → `resp_y`=1 with `resp_valid_0` one cycle after accept.
  - Same operands with sin_signo=1 → `resp_y`=0.
- Equality edge: a=b=0x80000000 in both modes → `resp_y`=0; a=0x80000000, b=0x7FFFFFFF, signed → 1, unsigned → 0.
- Contention with both valids held high and both `resp_ready` high:
  - With `ARBITRO_MENOR_RR_EN`: accepts alternate 0,1,0,1…
  - Without it: requester 0 is accepted every cycle and requester 1 is never readied.
- Backpressure: `resp_ready_1`=0 for 3 cycles with result pending → `resp_valid_1` and `resp_y` stable, both `req_ready` 0; raising `resp_ready_1` with `req_valid_0` high → drain and accept in the same cycle.
- Throughput: 8 back-to-back requests from requester 1 with `resp_ready_1`=1 → 8 results in 8 consecutive cycles, in order.
- Reset mid-operation: drop `nreset` with the buffer `LLENO` → `resp_valid_*`=0 immediately (no clock edge needed); after release, a tie grants requester 0.
